// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache port arbiter slice.
//   arbState_t  : arbiter FSM states (IDLE, ISSUE, WAIT, DONE)
//   PORT_FETCH  : port index of the instruction-fetch requester
//   PORT_DATA   : port index of the data requester
//   otherPort() : the port that is not the given one
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arbState_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  function automatic logic otherPort(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/cache_rr_picker.sv
// Two-way round-robin selector.
//   valid0, valid1 : requests pending on port 0 (fetch) and port 1 (data)
//   lastGrant      : port that won the previous arbitration
//   grant          : selected port index (meaningful when grantValid)
//   grantValid     : at least one port is requesting
module cache_rr_picker
  import cache_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic lastGrant,
  output logic grant,
  output logic grantValid
);

  always_comb begin
    grantValid = valid0 | valid1;
    grant      = PORT_FETCH;
    if (valid0 && valid1) begin
      // Contention: the port that did not win last time gets its turn.
      grant = otherPort(lastGrant);
    end else if (valid1) begin
      grant = PORT_DATA;
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Front end sharing a single write-through cache interface between an
// instruction-fetch port (0) and a data port (1).
//   clk, reset                : clock, synchronous active-high reset
//   reqN_valid/write/addr/wdata : requester N command
//   reqN_ready                : accept (combinational, IDLE only)
//   reqN_done                 : one-cycle completion pulse
//   reqN_rdata                : last successful read result of port N
//   err                       : pulses with done when the access timed out
//   cache_addr/wdata/read/write : strobes to the cache, held until stall clears
//   cache_stall, cache_rdata  : cache status and read data
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_done,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic                  cache_read,
  output logic                  cache_write,
  input  logic                  cache_stall,
  input  logic [DATA_WIDTH-1:0] cache_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arbState_t        state;
  logic             lastGrant;
  logic             latPort;
  logic [CNT_W-1:0] waitCnt;

  logic             grant;
  logic             grantValid;
  logic             selWrite;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selWdata;

  cache_rr_picker picker (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .lastGrant  (lastGrant),
    .grant      (grant),
    .grantValid (grantValid)
  );

  always_comb begin
    req0_ready = (state == IDLE) && grantValid && (grant == PORT_FETCH);
    req1_ready = (state == IDLE) && grantValid && (grant == PORT_DATA);
    if (grant == PORT_DATA) begin
      selWrite = req1_write;
      selAddr  = req1_addr;
      selWdata = req1_wdata;
    end else begin
      selWrite = req0_write;
      selAddr  = req0_addr;
      selWdata = req0_wdata;
    end
  end

  // The cache strobe registers double as the latched command: they are
  // loaded on the handshake and stay constant through ISSUE and WAIT, so
  // only the requesting port needs a separate latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lastGrant   <= PORT_DATA;
      latPort     <= PORT_FETCH;
      waitCnt     <= '0;
      cache_read  <= 1'b0;
      cache_write <= 1'b0;
      cache_addr  <= '0;
      cache_wdata <= '0;
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
      req0_rdata  <= '0;
      req1_rdata  <= '0;
      err         <= 1'b0;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (grantValid) begin
            latPort     <= grant;
            lastGrant   <= grant;
            cache_read  <= ~selWrite;
            cache_write <= selWrite;
            cache_addr  <= selAddr;
            cache_wdata <= selWdata;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          waitCnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (!cache_stall || (waitCnt == CNT_LAST)) begin
            // Completion or timeout abort: drop the strobes and raise the
            // done pulse for the DONE cycle. Only an unaborted read updates
            // the port's read data.
            cache_read  <= 1'b0;
            cache_write <= 1'b0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            err         <= cache_stall;
            if (latPort == PORT_DATA) begin
              req1_done <= 1'b1;
              if (!cache_stall && cache_read) req1_rdata <= cache_rdata;
            end else begin
              req0_done <= 1'b1;
              if (!cache_stall && cache_read) req0_rdata <= cache_rdata;
            end
            state <= DONE;
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
